// File: rtl/synth_pkg.sv
// Shared note/octave types and code constants for the synth voice path.
// Used by the voice arbiter, the melody ROM and the frequency ROM so all
// three agree on the encoding of a musical pitch.
package synth_pkg;

  typedef logic [3:0] note_t;
  typedef logic [1:0] octave_t;

  localparam note_t NOTE_C  = 4'd0;
  localparam note_t NOTE_CS = 4'd1;
  localparam note_t NOTE_D  = 4'd2;
  localparam note_t NOTE_DS = 4'd3;
  localparam note_t NOTE_E  = 4'd4;
  localparam note_t NOTE_F  = 4'd5;
  localparam note_t NOTE_FS = 4'd6;
  localparam note_t NOTE_G  = 4'd7;
  localparam note_t NOTE_GS = 4'd8;
  localparam note_t NOTE_A  = 4'd9;
  localparam note_t NOTE_AS = 4'd10;
  localparam note_t NOTE_B  = 4'd11;

  localparam octave_t OCT_0 = 2'd0;
  localparam octave_t OCT_1 = 2'd1;
  localparam octave_t OCT_2 = 2'd2;
  localparam octave_t OCT_3 = 2'd3;

endpackage

// File: rtl/synth_voice_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the previous winner; search starts at last+1 and wraps
//   valid - high when any request bit is set
//   idx   - index of the first requesting bit found
module rr_pick
  import synth_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  always_comb begin
    int unsigned pos;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = (32'(last) + k) % N_REQ;
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/synth_voice_arbiter.sv
// synth_voice_arbiter: shares one audio channel between N_REQ requesters.
// Round-robin grant, minimum hold time per owner, and a silent gap between
// owners. All outputs are registered.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset
//   req_i    - per-requester level-sensitive play request
//   note_i   - per-requester note code
//   octave_i - per-requester octave code
//   grant_o  - one-hot owner, zero when the channel is idle or in the gap
//   note_o   - note to the frequency ROM (held outside PLAY)
//   octave_o - octave to the frequency ROM (held outside PLAY)
//   enable_o - audio channel enable, high exactly when grant_o != 0
module synth_voice_arbiter
  import synth_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_CYC = 1_000_000,
  parameter int unsigned GAP_CYC  = 5_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_i,
  input  note_t   [N_REQ-1:0]  note_i,
  input  octave_t [N_REQ-1:0]  octave_i,
  output logic [N_REQ-1:0]     grant_o,
  output note_t                note_o,
  output octave_t              octave_o,
  output logic                 enable_o
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_last,  w_last_nxt;
  logic [IW-1:0]      r_owner, w_owner_nxt;
  logic [HW-1:0]      r_hold,  w_hold_nxt;
  logic [GW-1:0]      r_gap,   w_gap_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic               r_enable, w_enable_nxt;
  note_t              r_note,  w_note_nxt;
  octave_t            r_octave, w_octave_nxt;

  logic               w_pick_valid;
  logic [IW-1:0]      w_pick_idx;
  logic               w_hold_done;
  logic               w_others;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req_i),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // r_hold counts PLAY cycles already completed before the current one, so
  // the owner has played HOLD_CYC cycles once it reads HOLD_CYC-1; it stops
  // there and rotation is then allowed on every later cycle.
  assign w_hold_done = (r_hold == HW'(HOLD_CYC - 1));
  assign w_others    = |(req_i & ~r_grant);

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_hold_nxt   = r_hold;
    w_gap_nxt    = r_gap;
    w_grant_nxt  = r_grant;
    w_enable_nxt = r_enable;
    w_note_nxt   = r_note;
    w_octave_nxt = r_octave;

    unique case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt  = S_PLAY;
          w_last_nxt   = w_pick_idx;
          w_owner_nxt  = w_pick_idx;
          w_hold_nxt   = '0;
          w_grant_nxt  = N_REQ'(1) << w_pick_idx;
          w_enable_nxt = 1'b1;
          w_note_nxt   = note_i[w_pick_idx];
          w_octave_nxt = octave_i[w_pick_idx];
        end
      end
      S_PLAY: begin
        if (!req_i[r_owner] || (w_hold_done && w_others)) begin
          // Pitch is left untouched on the way out so the ROM sees no step
          // at the moment the channel mutes.
          w_state_nxt  = S_GAP;
          w_gap_nxt    = '0;
          w_grant_nxt  = '0;
          w_enable_nxt = 1'b0;
        end else begin
          w_note_nxt   = note_i[r_owner];
          w_octave_nxt = octave_i[r_owner];
          if (!w_hold_done) begin
            w_hold_nxt = r_hold + HW'(1);
          end
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_grant_nxt  = '0;
        w_enable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last   <= IW'(N_REQ - 1);
      r_owner  <= '0;
      r_hold   <= '0;
      r_gap    <= '0;
      r_grant  <= '0;
      r_enable <= 1'b0;
      r_note   <= '0;
      r_octave <= '0;
    end else begin
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_hold   <= w_hold_nxt;
      r_gap    <= w_gap_nxt;
      r_grant  <= w_grant_nxt;
      r_enable <= w_enable_nxt;
      r_note   <= w_note_nxt;
      r_octave <= w_octave_nxt;
    end
  end

  assign grant_o  = r_grant;
  assign enable_o = r_enable;
  assign note_o   = r_note;
  assign octave_o = r_octave;

endmodule

// File: doc/synth_voice_arbiter.md
SYNTH_VOICE_ARBITER -- requirements
Module: synth_voice_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter HOLD_CYC, default 1_000_000, minimum owner play time in clk cycles (>=1).
REQ-003 SHALL have parameter GAP_CYC, default 5_000, silent cycles between owners (>=1).
REQ-004 SHALL have port clk_i  input  1  the only clock.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  input  N_REQ  per-requester play request, level-sensitive.
REQ-007 SHALL have port note_i  input  N_REQ x 4  per-requester note code (C..B = 0..11).
REQ-008 SHALL have port octave_i  input  N_REQ x 2  per-requester octave code.
REQ-009 SHALL have port grant_o  output  N_REQ  one-hot current owner, all-zero when none.
REQ-010 SHALL have port note_o  output  4  note to the frequency ROM.
REQ-011 SHALL have port octave_o  output  2  octave to the frequency ROM.
REQ-012 SHALL have port enable_o  output  1  audio channel enable.

Function
REQ-013 SHALL implement an FSM with states IDLE, PLAY, GAP; all outputs registered.
REQ-014 In IDLE, if any req_i bit is set, SHALL pick the winner round-robin, searching from (last+1) mod N_REQ upward with wrap, and enter PLAY next cycle.
REQ-015 Latency: req_i asserted in cycle t from IDLE -> grant_o and enable_o high in t+1.
REQ-016 On grant, SHALL record the winner index as last.
REQ-017 SHALL clear and start the hold counter on entering PLAY, incrementing once per cycle and saturating at HOLD_CYC.
REQ-018 In PLAY, note_o/octave_o SHALL follow the owner's note_i/octave_i with one-cycle registered delay, so melody steps pass through.
REQ-019 In PLAY, if the owner deasserts req_i, SHALL enter GAP next cycle, regardless of hold count.
REQ-020 In PLAY, when hold count == HOLD_CYC and any other req_i bit is set, SHALL enter GAP next cycle (rotation).
REQ-021 In PLAY, when hold count == HOLD_CYC and no other request is set, SHALL keep the owner indefinitely.
REQ-022 In GAP, SHALL drive enable_o=0 and grant_o=0, and SHALL stay exactly GAP_CYC cycles, then enter IDLE.
REQ-023 In IDLE and GAP, note_o/octave_o SHALL hold their last values, with no frequency glitch.
REQ-024 grant_o SHALL never have more than one bit set; enable_o SHALL be 1 exactly when grant_o != 0.
REQ-025 Requests arriving during GAP SHALL be neither lost nor latched; arbitration samples req_i only in IDLE.

Reset
REQ-026 While rst_i is high, SHALL be in state IDLE, with grant_o=0, enable_o=0, note_o=0, octave_o=0, counters=0, last=N_REQ-1 (requester 0 wins first).
REQ-027 Assertion of rst_i mid-PLAY or mid-GAP SHALL force the reset values immediately, without waiting for a clock edge.

Structure
REQ-028 Package synth_pkg SHALL hold note_t (4-bit), octave_t (2-bit), and note/octave code constants shared with the melody ROM and frequency ROM.
REQ-029 The state enum SHALL be local to the module.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs req, last; outputs valid, idx).

Verification (N_REQ=4, HOLD_CYC=8, GAP_CYC=4)
REQ-031 Reset -> all outputs 0.
REQ-032 After reset release, req_i=0100 at cycle t -> grant_o=0100 and enable_o=1 at t+1.
- note_i[2] changes 3->9 -> note_o=9 one cycle later.
- req drop -> enable_o=0 next cycle, 4 GAP cycles, then IDLE.
REQ-033 req_i=0101 held from IDLE after reset -> requester 0 granted; after 8 PLAY cycles, GAP 4 cycles, then grant_o=0100.
REQ-034 Wrap-around: last=3 and req_i=1001 in IDLE -> grant_o=0001.
REQ-035 Lone owner with req held 40 cycles -> grant unchanged and enable_o continuously 1 (no rotation).
REQ-036 rst_i pulse mid-PLAY between clock edges -> enable_o and grant_o go 0 immediately; after release, req_i=0010 -> requester 1 granted one cycle later.
